// File: rtl/mat_wrapper.sv
// 2x2 matrix multiply of 2-bit unsigned operands, one 5-bit element computed per cycle.
// Latency: valid rises 4 cycles after the capture edge; result_out changes only on that edge.
// No backpressure: a load rise while computing is dropped; the result holds until the next job.
module mat_wrapper (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_in,
   input  logic [1:0]  a11,
   input  logic [1:0]  a12,
   input  logic [1:0]  a21,
   input  logic [1:0]  a22,
   input  logic [1:0]  b11,
   input  logic [1:0]  b12,
   input  logic [1:0]  b21,
   input  logic [1:0]  b22,
   output logic [19:0] result_out,
   output logic        valid
);

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t          state;
   logic            load_in_q;
   logic            load_rise;
   logic [3:0][1:0] op_a;
   logic [3:0][1:0] op_b;
   logic [1:0]      idx;
   logic [4:0]      c11_w;
   logic [4:0]      c12_w;
   logic [4:0]      c21_w;

   logic            row;
   logic            col;
   logic [3:0]      a_k0;
   logic [3:0]      a_k1;
   logic [3:0]      b_k0;
   logic [3:0]      b_k1;
   logic [3:0]      prod0;
   logic [3:0]      prod1;
   logic [4:0]      elem_sum;

   assign load_rise = load_in & ~load_in_q;

   // Operands are packed row-major: index {row,k} for A, {k,col} for B.
   always_comb begin
      row      = idx[1];
      col      = idx[0];
      a_k0     = {2'b00, op_a[{row, 1'b0}]};
      a_k1     = {2'b00, op_a[{row, 1'b1}]};
      b_k0     = {2'b00, op_b[{1'b0, col}]};
      b_k1     = {2'b00, op_b[{1'b1, col}]};
      prod0    = a_k0 * b_k0;
      prod1    = a_k1 * b_k1;
      elem_sum = {1'b0, prod0} + {1'b0, prod1};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         load_in_q  <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         idx        <= 2'd0;
         c11_w      <= 5'd0;
         c12_w      <= 5'd0;
         c21_w      <= 5'd0;
         result_out <= 20'd0;
         valid      <= 1'b0;
      end else begin
         load_in_q <= load_in;
         case (state)
            IDLE, DONE: begin
               if (load_rise) begin
                  op_a  <= {a22, a21, a12, a11};
                  op_b  <= {b22, b21, b12, b11};
                  idx   <= 2'd0;
                  valid <= 1'b0;
                  state <= COMPUTE;
               end
            end
            COMPUTE: begin
               idx <= idx + 2'd1;
               case (idx)
                  2'd0: c11_w <= elem_sum;
                  2'd1: c12_w <= elem_sum;
                  2'd2: c21_w <= elem_sum;
                  2'd3: begin
                     // Last element goes straight from the adder into the packed result.
                     result_out <= {elem_sum, c21_w, c12_w, c11_w};
                     valid      <= 1'b1;
                     state      <= DONE;
                  end
               endcase
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_wrapper.sv
// Randomised bench for mat_wrapper: an edge-level reference model pushes expected
// products into a scoreboard that a negedge monitor pops whenever valid rises.
module tb_mat_wrapper;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_in;
   logic [1:0]  a11, a12, a21, a22;
   logic [1:0]  b11, b12, b21, b22;
   logic [19:0] result_out;
   logic        valid;

   int n_cmp = 0;
   int n_err = 0;

   mat_wrapper dut (
      .clk(clk), .rst(rst), .load_in(load_in),
      .a11(a11), .a12(a12), .a21(a21), .a22(a22),
      .b11(b11), .b12(b12), .b21(b21), .b22(b22),
      .result_out(result_out), .valid(valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: C[r][c] = sum_k A[r][k]*B[k][c]; operand vectors are {x22,x21,x12,x11}.
   function automatic logic [19:0] mat_mul(input logic [7:0] av, input logic [7:0] bv);
      int A[2][2];
      int B[2][2];
      logic [19:0] res;
      res = '0;
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 2; k++) begin
            A[r][k] = int'(av[2*(2*r+k) +: 2]);
            B[r][k] = int'(bv[2*(2*r+k) +: 2]);
         end
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) begin
            int s;
            s = A[r][0]*B[0][c] + A[r][1]*B[1][c];
            res[5*(2*r+c) +: 5] = 5'(s);
         end
      return res;
   endfunction

   // Behavioural model evaluated at each rising edge (inputs change 1ns after edges).
   int          cyc = 0;
   bit          prev_ld = 1'b0;
   bit          have_job = 1'b0;
   int          last_cap = 0;
   logic [19:0] job_res;
   logic        exp_valid = 1'b0;
   logic [19:0] exp_res = '0;
   logic [19:0] exp_q[$];
   int          exp_cyc_q[$];

   always @(posedge clk) begin
      bit busy;
      cyc = cyc + 1;
      if (rst) begin
         prev_ld   = 1'b0;
         have_job  = 1'b0;
         exp_valid = 1'b0;
         exp_res   = '0;
         exp_q.delete();
         exp_cyc_q.delete();
      end else begin
         busy = have_job;
         if (have_job && cyc == last_cap + 4) begin
            exp_valid = 1'b1;
            exp_res   = job_res;
            have_job  = 1'b0;
         end
         if (load_in && !prev_ld && !busy) begin
            job_res   = mat_mul({a22, a21, a12, a11}, {b22, b21, b12, b11});
            last_cap  = cyc;
            have_job  = 1'b1;
            exp_valid = 1'b0;
            exp_q.push_back(job_res);
            exp_cyc_q.push_back(cyc + 4);
         end
         prev_ld = load_in;
      end
   end

   // Monitor: per-cycle state check plus scoreboard pop on each valid rise.
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      if (cyc > 0) begin
         check("valid", {19'd0, valid}, {19'd0, exp_valid});
         check("result_hold", result_out, exp_res);
         if (valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_valid: valid=1 with no job outstanding, result %h (t=%0t)",
                        result_out, $time);
            end else begin
               check("sb_result", result_out, exp_q.pop_front());
               check_int("sb_latency_cycle", cyc, exp_cyc_q.pop_front());
            end
         end
         prev_valid = valid;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input logic [7:0] av, input logic [7:0] bv);
      {a22, a21, a12, a11} = av;
      {b22, b21, b12, b11} = bv;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      load_in = 1'b0;
      set_ops(8'h00, 8'h00);

      // Reset, then idle with no load.
      tick(2);
      rst = 1'b0;
      tick(5);
      check("t1_result", result_out, 20'h00000);
      check("t1_valid", {19'd0, valid}, 20'd0);

      // All operands 3, load held two cycles: single job, every element 18.
      set_ops(8'hFF, 8'hFF);
      load_in = 1'b1;
      tick(2);
      load_in = 1'b0;
      tick(6);
      check("t2_result", result_out, 20'h94A52);
      check("t2_valid", {19'd0, valid}, 20'd1);

      // A=[[1,0],[0,1]], B=[[1,2],[3,0]]
      set_ops({2'd1, 2'd0, 2'd0, 2'd1}, {2'd0, 2'd3, 2'd2, 2'd1});
      load_in = 1'b1;
      tick(1);
      load_in = 1'b0;
      tick(6);
      check("t3_result", result_out, 20'h00C41);

      // A=[[1,2],[3,0]], B=[[2,1],[1,3]]
      set_ops({2'd0, 2'd3, 2'd2, 2'd1}, {2'd3, 2'd1, 2'd1, 2'd2});
      load_in = 1'b1;
      tick(1);
      load_in = 1'b0;
      tick(6);
      check("t4_result", result_out, 20'h198E4);

      // Load and operand changes during COMPUTE are ignored.
      set_ops({2'd1, 2'd0, 2'd0, 2'd1}, {2'd0, 2'd3, 2'd2, 2'd1});
      load_in = 1'b1;
      tick(1);
      load_in = 1'b0;
      tick(1);
      set_ops(8'hAA, 8'h55);
      load_in = 1'b1;
      tick(1);
      load_in = 1'b0;
      tick(3);
      check("t5_first_result", result_out, 20'h00C41);
      // New load from DONE: valid drops at capture, returns 4 cycles later.
      set_ops({2'd0, 2'd3, 2'd2, 2'd1}, {2'd3, 2'd1, 2'd1, 2'd2});
      load_in = 1'b1;
      tick(1);
      check("t5_valid_drop", {19'd0, valid}, 20'd0);
      check("t5_result_kept", result_out, 20'h00C41);
      load_in = 1'b0;
      tick(3);
      check("t5_valid_still_low", {19'd0, valid}, 20'd0);
      tick(1);
      check("t5_second_result", result_out, 20'h198E4);
      check("t5_valid_back", {19'd0, valid}, 20'd1);

      // Reset in the middle of a computation.
      set_ops(8'hFF, 8'hFF);
      load_in = 1'b1;
      tick(1);
      load_in = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
      check("t6_valid", {19'd0, valid}, 20'd0);
      check("t6_result", result_out, 20'h00000);
      rst = 1'b0;
      tick(8);

      // Random operands, load levels and occasional resets.
      for (int i = 0; i < 300; i++) begin
         set_ops(8'($urandom), 8'($urandom));
         load_in = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 39) == 0);
         tick(1);
      end
      rst = 1'b0;
      load_in = 1'b0;
      tick(10);
      check_int("pending_jobs", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
